// File: rtl/controller_pkg.sv
// Shared constants and types for the serial gamepad protocol.
// No logic; constants only.
// No flow control.
//
// Button bit positions follow the on-wire order: bit 7 is shifted first.
package controller_pkg;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT   = 2'd2,
        DRAINED = 2'd3
    } resp_state_e;

endpackage

// File: rtl/sync_edge_m.sv
// Multi-flop synchronizer for one async input, with rise/fall pulses.
// Latency: SYNC_STAGES cycles to level_o; pulses are combinational from it.
// No backpressure; the input is sampled every cycle.
//
// Ports: clk, rst_B (async active-low), async_i (raw input),
//        level_o (synchronized level), rise_o / fall_o (1-cycle pulses).
module sync_edge_m #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_B,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    // Pulses are decoded before the registered copy catches up, so the
    // consumer's register lands one cycle after the last sync stage.
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/controller_responder.sv
// Device side of the serial gamepad protocol: one emulated shift-register pad.
// Latency: host edge to data_out_B change is SYNC_STAGES+1 clk cycles.
// No backpressure; host edges are consumed as they arrive, extras flag overrun.
//
// Ports: clk, rst_B (async active-low); buttons_in/buttons_we stage the next
// button byte; controller_clk_in/controller_latch_in are the async host lines;
// data_out_B is the active-low serial line; bit_index, frame_done and the
// sticky overrun (cleared by overrun_clr) report frame progress.
module controller_responder
    import controller_pkg::*;
#(
    parameter int NUM_BITS    = NUM_BUTTONS,
    parameter int SYNC_STAGES = 2,
    parameter bit FILL_LEVEL  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_B,
    input  logic [NUM_BITS-1:0]           buttons_in,
    input  logic                          buttons_we,
    input  logic                          controller_clk_in,
    input  logic                          controller_latch_in,
    output logic                          data_out_B,
    output logic [$clog2(NUM_BITS+1)-1:0] bit_index,
    output logic                          frame_done,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    localparam int IDX_W = $clog2(NUM_BITS+1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NUM_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);

    logic clk_level, clk_rise, clk_fall;
    logic latch_level, latch_rise, latch_fall;

    sync_edge_m #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk     (clk),
        .rst_B   (rst_B),
        .async_i (controller_clk_in),
        .level_o (clk_level),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall)
    );

    sync_edge_m #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk     (clk),
        .rst_B   (rst_B),
        .async_i (controller_latch_in),
        .level_o (latch_level),
        .rise_o  (latch_rise),
        .fall_o  (latch_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, clk_level, clk_fall, latch_fall};

    resp_state_e              state_q, state_d;
    logic [NUM_BITS-1:0]      staging_q, staging_d;
    logic [NUM_BITS-1:0]      shift_q, shift_d;
    logic [IDX_W-1:0]         bit_index_q, bit_index_d;
    logic                     frame_done_q, frame_done_d;
    logic                     overrun_q, overrun_d;

    // FSM state register
    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a latch rise restarts the frame from anywhere and
    // swallows any clock edge arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        if (latch_rise) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE:    if (latch_level) state_d = LOAD;
                LOAD:    if (!latch_level) state_d = SHIFT;
                SHIFT:   if (clk_rise && bit_index_q == LAST_IDX) state_d = DRAINED;
                DRAINED: state_d = DRAINED;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        case (state_q)
            IDLE:    data_out_B = 1'b1;
            DRAINED: data_out_B = FILL_LEVEL;
            default: data_out_B = ~shift_q[NUM_BITS-1];
        endcase
    end

    // Datapath next state
    always_comb begin
        // A write in the load window bypasses staging straight into the shifter.
        staging_d    = buttons_we ? buttons_in : staging_q;
        shift_d      = shift_q;
        bit_index_d  = bit_index_q;
        frame_done_d = 1'b0;
        // Clear first so a same-cycle set below wins.
        overrun_d    = overrun_q & ~overrun_clr;

        if (state_d == LOAD || state_q == LOAD) begin
            shift_d     = staging_d;
            bit_index_d = '0;
        end else if (clk_rise) begin
            if (state_q == SHIFT) begin
                shift_d = shift_q << 1;
                if (bit_index_q < FULL_IDX) begin
                    bit_index_d = bit_index_q + IDX_W'(1);
                end
                if (bit_index_q == LAST_IDX) begin
                    frame_done_d = 1'b1;
                end
            end else if (state_q == DRAINED) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            staging_q    <= '0;
            shift_q      <= '0;
            bit_index_q  <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            staging_q    <= staging_d;
            shift_q      <= shift_d;
            bit_index_q  <= bit_index_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bit_index  = bit_index_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_controller_responder.sv
// Self-checking bench for controller_responder: host-side protocol driver,
// frame reference model, table vectors, random frames and corner sequences.
module tb_controller_responder;

    logic       clk;
    logic       rst_B;
    logic [7:0] buttons_in;
    logic       buttons_we;
    logic       cclk;
    logic       latch;
    logic       data_out_B;
    logic [3:0] bit_index;
    logic       frame_done;
    logic       overrun;
    logic       overrun_clr;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    controller_responder #(
        .NUM_BITS    (8),
        .SYNC_STAGES (2),
        .FILL_LEVEL  (1'b0)
    ) dut (
        .clk                 (clk),
        .rst_B               (rst_B),
        .buttons_in          (buttons_in),
        .buttons_we          (buttons_we),
        .controller_clk_in   (cclk),
        .controller_latch_in (latch),
        .data_out_B          (data_out_B),
        .bit_index           (bit_index),
        .frame_done          (frame_done),
        .overrun             (overrun),
        .overrun_clr         (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with frame_done high, so a count of 1 means one 1-cycle pulse.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    typedef struct {
        logic [7:0] stage;
        int         edges;
        logic       exp_line;
        int         exp_idx;
        int         exp_fd;
    } vec_t;

    vec_t vecs[8];

    // Reference: after k host clock edges the line shows the inverted k-th
    // button counted from bit 7; once all eight are out it shows the fill level.
    function automatic logic model_line(input logic [7:0] b, input int k);
        if (k >= 8) return 1'b0;
        return ~b[7-k];
    endfunction

    function automatic int model_idx(input int k);
        return (k > 8) ? 8 : k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic stage_buttons(input logic [7:0] b);
        buttons_in = b;
        buttons_we = 1'b1;
        tick();
        buttons_we = 1'b0;
    endtask

    task automatic latch_pulse();
        latch = 1'b1;
        wait_n(6);
        latch = 1'b0;
        wait_n(6);
    endtask

    task automatic clk_pulse();
        cclk = 1'b1;
        wait_n(6);
        cclk = 1'b0;
        wait_n(6);
    endtask

    initial begin
        int fd0;
        logic [7:0] b;
        int k;

        rst_B       = 1'b0;
        buttons_in  = 8'h00;
        buttons_we  = 1'b0;
        cclk        = 1'b0;
        latch       = 1'b0;
        overrun_clr = 1'b0;

        // Reset state
        tick();
        check("rst_line", data_out_B, 1);
        check("rst_idx", bit_index, 0);
        check("rst_fd", frame_done, 0);
        check("rst_ovr", overrun, 0);
        wait_n(2);
        rst_B = 1'b1;
        wait_n(3);

        // Exact latency: latch edge and clock edge both take 3 cycles to show
        stage_buttons(8'hA5);
        wait_n(2);
        check("idle_line", data_out_B, 1);
        fd0 = fd_cnt;
        latch = 1'b1;
        wait_n(2);
        check("lat_latch_early", data_out_B, 1);
        tick();
        check("lat_latch_on_time", data_out_B, 0);
        wait_n(5);
        latch = 1'b0;
        wait_n(6);
        cclk = 1'b1;
        wait_n(2);
        check("lat_clk_early", data_out_B, 0);
        tick();
        check("lat_clk_on_time", data_out_B, 1);
        check("lat_clk_idx", bit_index, 1);
        wait_n(3);
        cclk = 1'b0;
        wait_n(6);
        for (int e = 2; e <= 8; e++) begin
            clk_pulse();
            check($sformatf("a5_line_%0d", e), data_out_B, model_line(8'hA5, e));
        end
        check("a5_idx_end", bit_index, 8);
        check("a5_fd_pulses", fd_cnt - fd0, 1);
        check("a5_no_ovr", overrun, 0);

        // Overrun: extra edge sets it, clear works, set beats clear
        clk_pulse();
        check("ovr_set", overrun, 1);
        check("ovr_idx_sat", bit_index, 8);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        cclk = 1'b1;
        wait_n(2);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_set_clr_same", overrun, 1);
        wait_n(3);
        cclk = 1'b0;
        wait_n(6);

        // Reset mid-SHIFT aborts the frame; clock edges ignored until a latch
        latch_pulse();
        clk_pulse();
        clk_pulse();
        check("pre_rst_line", data_out_B, 0);
        check("pre_rst_idx", bit_index, 2);
        check("pre_rst_ovr_sticky", overrun, 1);
        rst_B = 1'b0;
        #1;
        check("midrst_line", data_out_B, 1);
        check("midrst_idx", bit_index, 0);
        check("midrst_ovr", overrun, 0);
        tick();
        rst_B = 1'b1;
        wait_n(3);
        clk_pulse();
        check("postrst_idx", bit_index, 0);
        check("postrst_line", data_out_B, 1);

        // Restart mid-frame with new staging
        stage_buttons(8'hA5);
        latch_pulse();
        for (int e = 0; e < 3; e++) clk_pulse();
        check("restart_pre_idx", bit_index, 3);
        stage_buttons(8'hFF);
        latch_pulse();
        check("restart_idx", bit_index, 0);
        for (int e = 0; e < 8; e++) begin
            check($sformatf("restart_line_%0d", e), data_out_B, 0);
            clk_pulse();
        end
        check("restart_fill", data_out_B, 0);
        check("restart_idx_end", bit_index, 8);

        // Collision: latch and clock rise together; write during load bypasses
        stage_buttons(8'h7E);
        latch_pulse();
        clk_pulse();
        clk_pulse();
        check("coll_pre_idx", bit_index, 2);
        latch = 1'b1;
        cclk  = 1'b1;
        wait_n(6);
        check("coll_idx", bit_index, 0);
        check("coll_first_bit", data_out_B, 1);
        cclk = 1'b0;
        wait_n(3);
        stage_buttons(8'h81);
        wait_n(3);
        latch = 1'b0;
        wait_n(6);
        for (int e = 0; e < 8; e++) begin
            check($sformatf("coll81_line_%0d", e), data_out_B, model_line(8'h81, e));
            clk_pulse();
        end
        check("coll81_fill", data_out_B, 0);

        // Table vectors
        vecs[0] = '{8'hA5, 0, 1'b0, 0, 0};
        vecs[1] = '{8'hA5, 3, 1'b1, 3, 0};
        vecs[2] = '{8'hA5, 8, 1'b0, 8, 1};
        vecs[3] = '{8'h3C, 1, 1'b1, 1, 0};
        vecs[4] = '{8'h3C, 2, 1'b0, 2, 0};
        vecs[5] = '{8'hFF, 5, 1'b0, 5, 0};
        vecs[6] = '{8'h00, 7, 1'b1, 7, 0};
        vecs[7] = '{8'h81, 7, 1'b0, 7, 0};
        for (int v = 0; v < 8; v++) begin
            stage_buttons(vecs[v].stage);
            fd0 = fd_cnt;
            latch_pulse();
            for (int e = 0; e < vecs[v].edges; e++) clk_pulse();
            check($sformatf("vec%0d_line", v), data_out_B, vecs[v].exp_line);
            check($sformatf("vec%0d_idx", v), bit_index, vecs[v].exp_idx);
            check($sformatf("vec%0d_fd", v), fd_cnt - fd0, vecs[v].exp_fd);
        end

        // Random frames against the reference model
        for (int f = 0; f < 24; f++) begin
            b = 8'($urandom);
            k = $urandom_range(0, 10);
            overrun_clr = 1'b1;
            tick();
            overrun_clr = 1'b0;
            stage_buttons(b);
            fd0 = fd_cnt;
            latch_pulse();
            check($sformatf("rnd%0d_first", f), data_out_B, model_line(b, 0));
            for (int j = 0; j < k; j++) begin
                // Staging writes mid-frame must not disturb the shifting frame.
                if (j == 2 && $urandom_range(0, 1) == 1) stage_buttons(8'($urandom));
                clk_pulse();
                check($sformatf("rnd%0d_line_%0d", f, j + 1), data_out_B, model_line(b, j + 1));
                check($sformatf("rnd%0d_idx_%0d", f, j + 1), bit_index, model_idx(j + 1));
            end
            check($sformatf("rnd%0d_ovr", f), overrun, (k > 8) ? 1 : 0);
            check($sformatf("rnd%0d_fd", f), fd_cnt - fd0, (k >= 8) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
